// File: rtl/data_stack_pkg.sv
// Shared processor datapath constants and the stack operation decode
// used by the data stack.
package data_stack_pkg;

   localparam int DATA_WIDTH  = 16;
   localparam int STACK_DEPTH = 16;

   typedef enum logic [2:0] {
      OP_NONE,
      OP_PUSH,
      OP_POP,
      OP_POP2,
      OP_REPLACE,
      OP_COLLAPSE
   } stack_op_e;

   // pop2 wins over pop; push combined with a pop becomes an in-place update.
   function automatic stack_op_e decode_op(input logic push, input logic pop, input logic pop2);
      stack_op_e op;
      if (push && pop2)      op = OP_COLLAPSE;
      else if (push && pop)  op = OP_REPLACE;
      else if (push)         op = OP_PUSH;
      else if (pop2)         op = OP_POP2;
      else if (pop)          op = OP_POP;
      else                   op = OP_NONE;
      return op;
   endfunction

endpackage

// File: rtl/data_stack_ram.sv
// Register-file storage for the data stack: one synchronous write port,
// two asynchronous read ports, no reset on the contents.
module stack_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/data_stack.sv
// LIFO data stack feeding TOS/NOS to the ALU; supports push, pop, pop2,
// replace and binary collapse in one cycle, with sticky error flags.
module data_stack
   import data_stack_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int DEPTH = STACK_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     pop2,
   input  logic [WIDTH-1:0]         din,
   input  logic                     clear_err,
   output logic [WIDTH-1:0]         tos,
   output logic [WIDTH-1:0]         nos,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] TWO      = CW'(2);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [CW-1:0]    cnt_q, cnt_nxt, cnt_m1, cnt_m2;
   logic             ovf_q, unf_q, ovf_evt, unf_evt;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] rd_a, rd_b;
   stack_op_e        op;

   assign cnt_m1 = cnt_q - ONE;
   assign cnt_m2 = cnt_q - TWO;

   // Illegal operations raise a flag and leave count and storage untouched.
   always_comb begin
      op      = decode_op(push, pop, pop2);
      cnt_nxt = cnt_q;
      we      = 1'b0;
      waddr   = cnt_q[AW-1:0];
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      unique case (op)
         OP_PUSH: begin
            if (cnt_q < FULL_CNT) begin
               we      = 1'b1;
               cnt_nxt = cnt_q + ONE;
            end else ovf_evt = 1'b1;
         end
         OP_POP: begin
            if (cnt_q >= ONE) cnt_nxt = cnt_m1;
            else unf_evt = 1'b1;
         end
         OP_POP2: begin
            if (cnt_q >= TWO) cnt_nxt = cnt_m2;
            else unf_evt = 1'b1;
         end
         OP_REPLACE: begin
            if (cnt_q >= ONE) begin
               we    = 1'b1;
               waddr = cnt_m1[AW-1:0];
            end else unf_evt = 1'b1;
         end
         OP_COLLAPSE: begin
            if (cnt_q >= TWO) begin
               we      = 1'b1;
               waddr   = cnt_m2[AW-1:0];
               cnt_nxt = cnt_m1;
            end else unf_evt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt;
         ovf_q <= (ovf_q && !clear_err) || ovf_evt;
         unf_q <= (unf_q && !clear_err) || unf_evt;
      end
   end

   stack_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we      (we && rst_n),
      .waddr   (waddr),
      .wdata   (din),
      .raddr_a (cnt_m1[AW-1:0]),
      .rdata_a (rd_a),
      .raddr_b (cnt_m2[AW-1:0]),
      .rdata_b (rd_b)
   );

   assign count     = cnt_q;
   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == FULL_CNT);
   assign tos       = (cnt_q >= ONE) ? rd_a : '0;
   assign nos       = (cnt_q >= TWO) ? rd_b : '0;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// Directed and randomized checks of data_stack against a queue-based
// LIFO reference model.
module tb_data_stack;

   localparam int W = 16;
   localparam int D = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          push = 1'b0, pop = 1'b0, pop2 = 1'b0, clear_err = 1'b0;
   logic [W-1:0]  din = '0;
   logic [W-1:0]  tos, nos;
   logic [4:0]    count;
   logic          empty, full, overflow, underflow;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] q[$];
   bit           m_ov = 0, m_uf = 0;

   data_stack #(.WIDTH(W), .DEPTH(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .pop2      (pop2),
      .din       (din),
      .clear_err (clear_err),
      .tos       (tos),
      .nos       (nos),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      check({tag, ".tos"},   32'(tos),   (n >= 1) ? 32'(q[n-1]) : 32'd0);
      check({tag, ".nos"},   32'(nos),   (n >= 2) ? 32'(q[n-2]) : 32'd0);
      check({tag, ".count"}, 32'(count), 32'(n));
      check({tag, ".empty"}, 32'(empty), 32'(n == 0));
      check({tag, ".full"},  32'(full),  32'(n == D));
      check({tag, ".ovf"},   32'(overflow),  32'(m_ov));
      check({tag, ".unf"},   32'(underflow), 32'(m_uf));
   endtask

   // Reference behaviour from the operation rules, on a plain queue (back = TOS).
   task automatic model_apply(input bit p, input bit po, input bit p2,
                              input logic [W-1:0] d, input bit clr);
      int n;
      bit e_ov, e_uf;
      n = q.size();
      e_ov = 0;
      e_uf = 0;
      if (p && p2) begin
         if (n >= 2) begin void'(q.pop_back()); void'(q.pop_back()); q.push_back(d); end
         else e_uf = 1;
      end else if (p && po) begin
         if (n >= 1) q[n-1] = d;
         else e_uf = 1;
      end else if (p) begin
         if (n < D) q.push_back(d);
         else e_ov = 1;
      end else if (p2) begin
         if (n >= 2) begin void'(q.pop_back()); void'(q.pop_back()); end
         else e_uf = 1;
      end else if (po) begin
         if (n >= 1) void'(q.pop_back());
         else e_uf = 1;
      end
      if (clr) begin m_ov = 0; m_uf = 0; end
      if (e_ov) m_ov = 1;
      if (e_uf) m_uf = 1;
   endtask

   task automatic step(input bit p, input bit po, input bit p2,
                       input logic [W-1:0] d, input bit clr, input string tag);
      push = p; pop = po; pop2 = p2; din = d; clear_err = clr;
      @(posedge clk); #1;
      model_apply(p, po, p2, d, clr);
      push = 0; pop = 0; pop2 = 0; clear_err = 0;
      check_all(tag);
   endtask

   // Reset with a push held active to show it is discarded.
   task automatic reset_cycles(input int ncyc, input string tag);
      rst_n = 0; push = 1; din = 16'hBEEF; clear_err = 0;
      repeat (ncyc) @(posedge clk);
      #1;
      q.delete();
      m_ov = 0;
      m_uf = 0;
      push = 0;
      check_all(tag);
      rst_n = 1;
   endtask

   initial begin
      int r;
      reset_cycles(2, "reset");
      step(0, 1, 0, '0, 0, "pop_empty");
      step(0, 0, 0, '0, 1, "clr1");

      step(1, 0, 0, 16'h0061, 0, "push61");
      step(1, 0, 0, 16'hFF80, 0, "pushFF80");
      check("imm.tos", 32'(tos), 32'h0000FF80);
      check("imm.nos", 32'(nos), 32'h00000061);
      step(0, 1, 0, '0, 0, "pop1");
      check("pop1.nos0", 32'(nos), 32'd0);
      step(0, 1, 0, '0, 0, "pop_to0");

      step(1, 0, 0, 16'h0005, 0, "push5");
      step(1, 0, 0, 16'h0003, 0, "push3");
      step(1, 0, 1, 16'h0008, 0, "collapse");
      check("collapse.tos", 32'(tos), 32'h8);
      step(0, 1, 0, '0, 0, "pop_c");

      for (int i = 1; i <= 16; i++) step(1, 0, 0, W'(i), 0, "fill");
      check("fill.full", 32'(full), 32'd1);
      check("fill.tos",  32'(tos),  32'h10);
      step(1, 0, 0, 16'h1234, 0, "push17");
      check("push17.ovf", 32'(overflow), 32'd1);
      step(1, 1, 0, 16'hFFDF, 0, "replace_full");
      step(1, 0, 1, 16'h7777, 0, "collapse_full");
      step(0, 0, 0, '0, 1, "clr_full");

      while (q.size() > 1) step(0, 1, 0, '0, 0, "drain");
      step(0, 0, 1, '0, 0, "pop2_cnt1");
      check("pop2_cnt1.unf", 32'(underflow), 32'd1);
      step(0, 0, 1, '0, 1, "clr_and_err");
      step(0, 0, 0, '0, 1, "clr_only");
      check("clr_only.unf", 32'(underflow), 32'd0);
      step(1, 1, 0, 16'hAAAA, 0, "replace_c1");
      step(0, 1, 1, '0, 0, "pop_pop2_prec");

      while (q.size() < 5) step(1, 0, 0, W'($urandom), 0, "to5");
      reset_cycles(1, "mid_reset");
      step(1, 0, 0, 16'h4242, 0, "after_reset");

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 63) == 0) begin
            reset_cycles(1, "rnd_reset");
         end else begin
            r = $urandom_range(0, 9);
            case (r)
               0, 1, 2, 3: step(1, 0, 0, W'($urandom), $urandom_range(0, 15) == 0, "rnd_push");
               4:          step(0, 1, 0, W'($urandom), $urandom_range(0, 15) == 0, "rnd_pop");
               5:          step(0, 0, 1, W'($urandom), $urandom_range(0, 15) == 0, "rnd_pop2");
               6:          step(1, 1, 0, W'($urandom), $urandom_range(0, 15) == 0, "rnd_repl");
               7:          step(1, $urandom_range(0, 1) == 1, 1, W'($urandom), $urandom_range(0, 15) == 0, "rnd_coll");
               8:          step(0, 0, 0, W'($urandom), $urandom_range(0, 3) == 0, "rnd_idle");
               default:    step(0, 1, 1, W'($urandom), $urandom_range(0, 15) == 0, "rnd_prec");
            endcase
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
